// File: rtl/ahb_arbiter_param.sv
// rtl/ahb_arbiter_param.sv - parametrised AHB bus arbiter with fixed-priority and round-robin modes
module ahb_arbiter_param #(
    parameter int MasNum    = 4,
    parameter int PrioW     = 2,
    parameter int DefMaster = 0,
    localparam int MW       = (MasNum > 1) ? $clog2(MasNum) : 1
) (
    input  logic                    i_hclk,
    input  logic                    i_hreset_n,
    input  logic [MasNum-1:0]       i_hbusreq,
    input  logic [MasNum-1:0]       i_hlock,
    input  logic [MasNum*PrioW-1:0] i_hprior,
    input  logic                    i_rr_mode,
    input  logic [1:0]              i_htrans,
    input  logic [2:0]              i_hburst,
    input  logic                    i_hready,
    output logic [MasNum-1:0]       o_hgrant,
    output logic [MW-1:0]           o_hmaster,
    output logic                    o_hmastlock
);

    localparam logic [1:0] HT_IDLE   = 2'd0;
    localparam logic [1:0] HT_BUSY   = 2'd1;
    localparam logic [1:0] HT_NONSEQ = 2'd2;
    localparam logic [1:0] HT_SEQ    = 2'd3;

    localparam logic [MasNum-1:0] DEF_GRANT = MasNum'(1) << DefMaster;
    localparam logic [MW-1:0]     DEF_IDX   = MW'(DefMaster);
    localparam logic [MW:0]       NUM_M     = (MW+1)'(MasNum);

    logic [MasNum-1:0] r_hgrant;
    logic [MW-1:0]     r_hmaster;
    logic              r_hmastlock;
    logic [4:0]        r_rem;
    logic [MW-1:0]     r_rr_ptr;

    logic [MW-1:0]     w_grant_idx;
    logic [MW-1:0]     w_fp_idx;
    logic [PrioW-1:0]  w_fp_prio;
    logic              w_fp_found;
    logic [MW-1:0]     w_rr_idx;
    logic              w_rr_found;
    logic              w_any_req;
    logic [MW-1:0]     w_win_idx;
    logic [MW-1:0]     w_rr_next;
    logic [4:0]        w_next_rem;
    logic              w_lock_hold;
    logic              w_arb_en;

    assign o_hgrant    = r_hgrant;
    assign o_hmaster   = r_hmaster;
    assign o_hmastlock = r_hmastlock;

    assign w_any_req   = |i_hbusreq;

    // Encode the one-hot grant register into the index of the current owner
    always_comb begin
        w_grant_idx = '0;
        for (int i = 0; i < MasNum; i++) begin
            if (r_hgrant[i]) begin
                w_grant_idx = MW'(i);
            end
        end
    end

    // Fixed priority: strictly greater priority wins, so ties stay with the lowest index
    always_comb begin
        w_fp_idx   = '0;
        w_fp_prio  = '0;
        w_fp_found = 1'b0;
        for (int i = 0; i < MasNum; i++) begin
            if (i_hbusreq[i] && (!w_fp_found || (i_hprior[i*PrioW +: PrioW] > w_fp_prio))) begin
                w_fp_found = 1'b1;
                w_fp_prio  = i_hprior[i*PrioW +: PrioW];
                w_fp_idx   = MW'(i);
            end
        end
    end

    // Round robin: first requester scanning upward from the pointer, wrapping at MasNum
    always_comb begin
        logic [MW:0] v_pos;
        v_pos      = '0;
        w_rr_idx   = '0;
        w_rr_found = 1'b0;
        for (int k = 0; k < MasNum; k++) begin
            v_pos = {1'b0, r_rr_ptr} + (MW+1)'(k);
            if (v_pos >= NUM_M) begin
                v_pos = v_pos - NUM_M;
            end
            if (!w_rr_found && i_hbusreq[v_pos[MW-1:0]]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = v_pos[MW-1:0];
            end
        end
    end

    // Pick the winner for the active mode; the default master parks the bus when idle
    always_comb begin
        logic [MW:0] v_nxt;
        if (!w_any_req) begin
            w_win_idx = DEF_IDX;
        end else if (i_rr_mode) begin
            w_win_idx = w_rr_idx;
        end else begin
            w_win_idx = w_fp_idx;
        end
        v_nxt = {1'b0, w_win_idx} + {{MW{1'b0}}, 1'b1};
        if (v_nxt >= NUM_M) begin
            v_nxt = '0;
        end
        w_rr_next = v_nxt[MW-1:0];
    end

    // Remaining-beat count after this edge; fixed bursts load len-1, IDLE aborts
    always_comb begin
        w_next_rem = r_rem;
        if (i_hready) begin
            case (i_htrans)
                HT_IDLE: w_next_rem = 5'd0;
                HT_BUSY: w_next_rem = r_rem;
                HT_NONSEQ: begin
                    case (i_hburst)
                        3'd2, 3'd3: w_next_rem = 5'd3;
                        3'd4, 3'd5: w_next_rem = 5'd7;
                        3'd6, 3'd7: w_next_rem = 5'd15;
                        default:    w_next_rem = 5'd0;
                    endcase
                end
                HT_SEQ: w_next_rem = (r_rem != 5'd0) ? (r_rem - 5'd1) : 5'd0;
                default: w_next_rem = r_rem;
            endcase
        end
    end

    // Re-arbitrate only at the last-but-one beat of a burst and never inside a live lock
    always_comb begin
        w_lock_hold = i_hlock[w_grant_idx] & i_hbusreq[w_grant_idx];
        w_arb_en    = i_hready & (w_next_rem <= 5'd1) & ~w_lock_hold;
    end

    // Grant, address-phase owner, lock flag, burst counter and round-robin pointer
    always_ff @(posedge i_hclk or negedge i_hreset_n) begin
        if (!i_hreset_n) begin
            r_hgrant    <= DEF_GRANT;
            r_hmaster   <= DEF_IDX;
            r_hmastlock <= 1'b0;
            r_rem       <= 5'd0;
            r_rr_ptr    <= '0;
        end else if (i_hready) begin
            r_rem       <= w_next_rem;
            r_hmaster   <= w_grant_idx;
            r_hmastlock <= i_hlock[w_grant_idx];
            if (w_arb_en) begin
                r_hgrant <= MasNum'(1) << w_win_idx;
                if (i_rr_mode && w_any_req) begin
                    r_rr_ptr <= w_rr_next;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_arbiter_param.sv
// tb/tb_ahb_arbiter_param.sv - self-checking bench for ahb_arbiter_param
module tb_ahb_arbiter_param;

    localparam int NM  = 4;
    localparam int DEF = 2;

    logic       hclk     = 1'b0;
    logic       hreset_n = 1'b1;
    logic [3:0] hbusreq  = '0;
    logic [3:0] hlock    = '0;
    logic [7:0] hprior   = '0;
    logic       rr_mode  = 1'b0;
    logic [1:0] htrans   = 2'd0;
    logic [2:0] hburst   = 3'd0;
    logic       hready   = 1'b1;
    logic [3:0] hgrant;
    logic [1:0] hmaster;
    logic       hmastlock;

    int errors = 0;
    int checks = 0;

    int m_grant, m_master, m_ptr, m_rem;
    bit m_lock;

    ahb_arbiter_param #(.MasNum(NM), .PrioW(2), .DefMaster(DEF)) dut (
        .i_hclk     (hclk),
        .i_hreset_n (hreset_n),
        .i_hbusreq  (hbusreq),
        .i_hlock    (hlock),
        .i_hprior   (hprior),
        .i_rr_mode  (rr_mode),
        .i_htrans   (htrans),
        .i_hburst   (hburst),
        .i_hready   (hready),
        .o_hgrant   (hgrant),
        .o_hmaster  (hmaster),
        .o_hmastlock(hmastlock)
    );

    always #5 hclk = ~hclk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_grant  = DEF;
        m_master = DEF;
        m_lock   = 1'b0;
        m_rem    = 0;
        m_ptr    = 0;
    endtask

    task automatic model_step();
        int nrem, w, best, score, b, nm;
        bit nl;
        if (!hready) return;
        b = int'(hburst);
        case (htrans)
            2'd0:    nrem = 0;
            2'd1:    nrem = m_rem;
            2'd2:    nrem = (b < 2) ? 0 : ((4 << ((b >> 1) - 1)) - 1);
            default: nrem = (m_rem > 0) ? m_rem - 1 : 0;
        endcase
        nm = m_grant;
        nl = hlock[m_grant];
        if (nrem <= 1 && !(hlock[m_grant] && hbusreq[m_grant])) begin
            w = DEF;
            best = -1;
            for (int i = 0; i < NM; i++) begin
                if (hbusreq[i]) begin
                    if (rr_mode) score = NM - ((i - m_ptr + NM) % NM);
                    else         score = int'(hprior[i*2 +: 2]) * NM + (NM - 1 - i);
                    if (score > best) begin
                        best = score;
                        w = i;
                    end
                end
            end
            m_grant = w;
            if (rr_mode && best >= 0) m_ptr = (w + 1) % NM;
        end
        m_master = nm;
        m_lock   = nl;
        m_rem    = nrem;
    endtask

    task automatic tick();
        if (hreset_n) model_step();
        else          model_reset();
        @(posedge hclk);
        #1;
        chk("model_grant", hgrant, 32'(1 << m_grant));
        chk("model_master", hmaster, 32'(m_master));
        chk("model_lock", hmastlock, 32'(m_lock));
        chk("onehot", 32'($onehot(hgrant)), 32'd1);
    endtask

    initial begin
        int prev;
        int rr_seq [6] = '{0, 1, 3, 0, 1, 3};

        model_reset();
        #2 hreset_n = 1'b0;
        #1;
        chk("rst_grant", hgrant, 32'h4);
        chk("rst_master", hmaster, 32'd2);
        chk("rst_lock", hmastlock, 32'd0);
        tick();
        tick();
        hreset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_grant", hgrant, 32'h4);
            chk("idle_master", hmaster, 32'd2);
            chk("idle_lock", hmastlock, 32'd0);
        end

        // fixed priority {3,1,3,0}
        hprior  = {2'd3, 2'd1, 2'd3, 2'd0};
        hbusreq = 4'b1111;
        htrans  = 2'd2;
        hburst  = 3'd0;
        tick();
        chk("fp_grant1", hgrant, 32'h2);
        tick();
        chk("fp_master1", hmaster, 32'd1);
        hbusreq = 4'b1101;
        tick();
        chk("fp_grant3", hgrant, 32'h8);
        tick();
        chk("fp_master3", hmaster, 32'd3);

        // round robin
        rr_mode = 1'b1;
        hbusreq = 4'b1011;
        prev = 3;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("rr_grant", hgrant, 32'(1 << rr_seq[i]));
            chk("rr_master_lag", hmaster, 32'(prev));
            prev = rr_seq[i];
        end

        // INCR4 handover without wait states
        rr_mode = 1'b0;
        hprior  = {2'd0, 2'd0, 2'd1, 2'd3};
        hbusreq = 4'b0011;
        htrans  = 2'd0;
        tick();
        chk("incr4_own", hgrant, 32'h1);
        tick();
        hbusreq = 4'b0010;
        htrans  = 2'd2;
        hburst  = 3'd3;
        tick();
        chk("incr4_b1", hgrant, 32'h1);
        htrans = 2'd3;
        tick();
        chk("incr4_b2", hgrant, 32'h1);
        tick();
        chk("incr4_b3_handover", hgrant, 32'h2);
        chk("incr4_b3_master", hmaster, 32'd0);
        tick();
        chk("incr4_b4_master", hmaster, 32'd1);

        // INCR4 with two wait states mid-burst
        htrans  = 2'd0;
        hbusreq = 4'b0001;
        tick();
        tick();
        chk("incr4w_own", hmaster, 32'd0);
        hbusreq = 4'b0010;
        htrans  = 2'd2;
        tick();
        htrans = 2'd3;
        tick();
        hready = 1'b0;
        tick();
        tick();
        chk("incr4w_frozen", hgrant, 32'h1);
        hready = 1'b1;
        tick();
        chk("incr4w_handover", hgrant, 32'h2);
        tick();
        chk("incr4w_master", hmaster, 32'd1);

        // locked sequence by master 2 against higher-priority master 0
        htrans  = 2'd2;
        hburst  = 3'd0;
        hbusreq = 4'b0100;
        hlock   = 4'b0100;
        tick();
        chk("lock_own", hgrant, 32'h4);
        hbusreq = 4'b0101;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("lock_grant", hgrant, 32'h4);
            chk("lock_mastlock", hmastlock, 32'd1);
        end
        hlock = 4'b0000;
        tick();
        chk("lock_release", hgrant, 32'h1);

        // WRAP8 terminated by IDLE after beat 3
        hbusreq = 4'b0100;
        hburst  = 3'd4;
        htrans  = 2'd2;
        tick();
        htrans = 2'd3;
        tick();
        tick();
        chk("wrap8_hold", hgrant, 32'h1);
        htrans = 2'd0;
        tick();
        chk("wrap8_idle_rearb", hgrant, 32'h4);

        // reset asserted mid INCR16
        hbusreq = 4'b0001;
        tick();
        hbusreq = 4'b0000;
        hburst  = 3'd7;
        htrans  = 2'd2;
        tick();
        htrans = 2'd3;
        tick();
        tick();
        chk("incr16_hold", hgrant, 32'h1);
        hreset_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst_grant", hgrant, 32'h4);
        chk("async_rst_master", hmaster, 32'd2);
        chk("async_rst_lock", hmastlock, 32'd0);

        // randomized traffic against the reference model
        hreset_n = 1'b1;
        for (int i = 0; i < 400; i++) begin
            hbusreq = 4'($urandom);
            hlock   = 4'($urandom) & 4'($urandom);
            hprior  = 8'($urandom);
            if ($urandom_range(0, 7) == 0) rr_mode = ~rr_mode;
            htrans  = 2'($urandom);
            hburst  = 3'($urandom);
            hready  = ($urandom_range(0, 4) != 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ahb_arbiter_param.md
# ahb_arbiter_param

Parametrised AHB arbiter for the generated AHB bus, replacing fixed per-master arbitration for any master count. It samples bus requests, lock and priority from `MasNum` masters, grants one master at a time, and drives `hmaster`/`hmastlock` for the bus address/data muxes. It supports runtime-selectable fixed-priority and round-robin modes. Fixed-length bursts and locked sequences are never broken.

## Interface
- `MasNum`, 4, number of masters (2..16)
- `PrioW`, 2, width of each master's priority field
- `DefMaster`, 0, master index granted when nobody requests
- `hclk` in 1, bus clock; all state on rising edge
- `hreset_n` in 1, reset; one clock; reset is asynchronous and active-low
- `hbusreq` in MasNum, per-master bus request
- `hlock` in MasNum, per-master locked-transfer request
- `hprior` in MasNum*PrioW, packed priorities; master i at [i*PrioW +: PrioW]
- `rr_mode` in 1, 1 = round-robin, 0 = fixed priority
- `htrans` in 2, bus HTRANS (IDLE=0, BUSY=1, NONSEQ=2, SEQ=3)
- `hburst` in 3, bus HBURST
- `hready` in 1, bus HREADY
- `hgrant` out MasNum, one-hot grant
- `hmaster` out max(1,$clog2(MasNum)), index of the master owning the address phase
- `hmastlock` out 1, current address phase is locked

## Operation
- Winner selection is combinational. If `rr_mode`=0, the highest `hprior` among requesters wins; ties go to the lowest index. If `rr_mode`=1, the first requester at or after `rr_ptr` wins, with index wrap. If there are no requests, the winner is `DefMaster`.
- Burst tracking uses a `rem` counter (5 bits) and is updated only when `hready`=1:
  - NONSEQ with INCR4/WRAP4 sets `rem`=3; INCR8/WRAP8 sets `rem`=7; INCR16/WRAP16 sets `rem`=15. SINGLE or INCR sets `rem`=0.
  - SEQ with `rem`>0 decrements `rem`.
  - BUSY holds `rem`.
  - IDLE clears `rem`, which terminates the burst early.
  - `next_rem` is the value `rem` takes at this edge.
- `arb_en` = `hready` & (`next_rem` <= 1) & ~(`hlock[hmaster_grant]` & `hbusreq[hmaster_grant]`). Here `hmaster_grant` is the currently granted index.
- When `arb_en`=1, `hgrant` is loaded with the one-hot winner. In round-robin mode, `rr_ptr` is set to winner+1 mod `MasNum`, but only if the winner was a real requester.
- When `hready`=1, `hmaster` is loaded with the index of `hgrant` and `hmastlock` is loaded with `hlock[granted]`. Otherwise both hold.
- A locked master keeps the grant while it asserts both `hlock` and `hbusreq`. The grant is released on the first `arb_en` edge after it drops either signal.
- `rr_mode` changes take effect at the next `arb_en` edge. `rr_ptr` is retained across mode changes.

## Timing
- Reset values:
  - `hgrant` = one-hot(`DefMaster`)
  - `hmaster` = `DefMaster`
  - `hmastlock` = 0
  - `rem` = 0
  - `rr_ptr` = 0
- Latency: a request is seen at edge N, `hgrant` is valid after N, and `hmaster` switches at the next edge with `hready`=1. Minimum is 2 cycles from request to address ownership.
- `hready`=0 freezes all state (`hgrant`, `hmaster`, `hmastlock`, `rem`, `rr_ptr`).
- Fixed bursts: the grant can change at the edge accepting beat len-1, so the new owner's address follows the last beat with no gap.
- Exactly one bit of `hgrant` is set at all times.
- Reset asserted mid-burst clears all state immediately, without waiting for an edge.
- If the granted master drops its request mid-burst, the burst still holds the grant until `next_rem` <= 1 or until IDLE is seen.

## Test plan
- Reset check: hold `hreset_n`=0 with `DefMaster`=2, `MasNum`=4 -> `hgrant`=4'b0100, `hmaster`=2, `hmastlock`=0. Then release with no requests -> outputs unchanged for 10 cycles.
- Fixed priority: set `hprior`={3,1,3,0} (master3..0) and `hbusreq`=4'b1111 -> grant master 1; dropping `hbusreq[1]` -> grant master 3.
- Round-robin: set `rr_mode`=1 and hold `hbusreq`=4'b1011 with SINGLE NONSEQ every cycle, `hready`=1 -> grant sequence 0,1,3,0,1,3. `hmaster` lags `hgrant` by one cycle.
- INCR4 hold:
  - Master 0 issues NONSEQ+3×SEQ while master 1 requests -> `hgrant` stays master 0 until beat 3 is accepted, then switches.
  - `hmaster`=1 on the cycle after beat 4.
  - Repeat with `hready` low for 2 cycles mid-burst -> same handover, delayed by 2.
- Lock: master 2 holds `hlock`=1 and `hbusreq`=1 for 6 SINGLE transfers while master 0 requests at higher priority -> master 2 keeps the grant and `hmastlock`=1. Releasing the lock -> grant moves to master 0 on the next edge.
- Early termination: during a WRAP8, send IDLE after beat 3 -> `rem`=0 and re-arbitration occurs at that edge. Also assert `hreset_n` low mid-INCR16 -> reset values appear immediately.
